// File: rtl/tdc_hist_reader_pkg.sv
// Shared definitions for the TDC histogram reader: default sizes, FSM state
// encodings, TDC channel codes and event classification.
package tdc_hist_reader_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int NBINS_DEF = 128;

  // FSM state encoding (plain 2-bit constants so the state is easy to probe)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACQ   = 2'd1;
  localparam state_t ST_CLEAR = 2'd2;
  localparam state_t ST_DUMP  = 2'd3;

  // TDC channel codes, {pulse1,pulse2}
  localparam logic [1:0] CODE_COINC_START = 2'b00;
  localparam logic [1:0] CODE_COINC_END   = 2'b11;
  localparam logic [1:0] CODE_P1          = 2'b10;
  localparam logic [1:0] CODE_P2          = 2'b01;

  typedef enum logic [1:0] {
    EV_COINC = 2'd0,
    EV_CROSS = 2'd1,
    EV_AUTO  = 2'd2
  } ev_kind_e;

  // Zero-delay coincidence, cross event (P1->P2 or P2->P1), or anything else
  function automatic ev_kind_e classify(input logic [1:0] start_code,
                                        input logic [1:0] end_code);
    if (start_code == CODE_COINC_START && end_code == CODE_COINC_END)
      return EV_COINC;
    else if ((start_code == CODE_P1 && end_code == CODE_P2) ||
             (start_code == CODE_P2 && end_code == CODE_P1))
      return EV_CROSS;
    else
      return EV_AUTO;
  endfunction

endpackage

// File: rtl/tdc_hist_ram.sv
// Simple dual-port synchronous RAM, one write port and one read port,
// 1-cycle read latency. A read of the address being written in the same
// cycle returns the old contents. Contents are not reset.
module tdc_hist_ram #(
  parameter int DW = 16,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_q;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/tdc_hist_reader.sv
// TDC histogram reader: synchronises the TDC event strobe, classifies each
// event, accumulates cross events into a RAM histogram through a 2-stage
// read-modify-write pipeline, keeps coincidence/auto/total counters, and
// supports bulk clear and a valid/ready readout stream.
//
// Readout handshake: a word transfers on a rising clk edge where
// m_valid & m_ready are both 1. Once m_valid is raised, m_data, m_last and
// m_valid hold until that transfer. m_valid is a register output and never
// depends combinationally on m_ready.
module tdc_hist_reader
  import tdc_hist_reader_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NBINS = NBINS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       START_signal,
  input  logic [1:0]       END_signal,
  input  logic [6:0]       INTERVAL,
  input  logic             data_arrived,
  input  logic             acq_en,
  input  logic             clear_req,
  input  logic             dump_req,
  output logic             busy,
  output logic [CNT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [1:0]       o_dbg_state
);

  localparam int AW = $clog2(NBINS);
  localparam int IW = $clog2(NBINS + 3);
  localparam logic [AW-1:0] TOP_ADDR = AW'(NBINS - 1);
  localparam logic [IW-1:0] IDX_COINC = IW'(NBINS);
  localparam logic [IW-1:0] IDX_AUTO  = IW'(NBINS + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NBINS + 2);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  logic             r_sync1, r_sync2, r_sync3;
  logic             w_event, w_accept;
  ev_kind_e         w_kind;
  logic [AW-1:0]    w_bin_addr;
  logic             r_s1_valid, r_s2_valid, r_fwd_valid;
  logic [AW-1:0]    r_s1_addr, r_s2_addr, r_fwd_addr;
  logic [CNT_W-1:0] r_fwd_data;
  logic [CNT_W-1:0] r_coinc, r_auto, r_total;
  logic [AW-1:0]    r_clr_addr;
  logic [IW-1:0]    r_idx;
  logic             r_rd_pend;
  logic [CNT_W-1:0] r_m_data;
  logic             r_m_valid, r_m_last;
  logic             w_pipe_busy, w_clr_we, w_dump_go;
  logic             w_ram_we;
  logic [AW-1:0]    w_ram_waddr, w_ram_raddr;
  logic [CNT_W-1:0] w_ram_wdata, w_ram_q, w_old, w_word;

  assign w_event     = r_sync2 & ~r_sync3;
  assign w_kind      = classify(START_signal, END_signal);
  assign w_bin_addr  = AW'(INTERVAL);
  assign w_accept    = w_event & acq_en & (r_state == ST_ACQ);
  assign w_pipe_busy = r_s1_valid | r_s2_valid;
  // CLEAR and DUMP only touch the RAM once the RMW pipeline has drained
  assign w_clr_we    = (r_state == ST_CLEAR) & ~w_pipe_busy;
  assign w_dump_go   = (r_state == ST_DUMP) & ~w_pipe_busy;

  // Last write is forwarded because a same-cycle read returns the old value
  assign w_old       = (r_fwd_valid && r_fwd_addr == r_s2_addr) ? r_fwd_data : w_ram_q;
  assign w_ram_we    = r_s2_valid | w_clr_we;
  assign w_ram_waddr = r_s2_valid ? r_s2_addr : r_clr_addr;
  assign w_ram_wdata = r_s2_valid ? sat_inc(w_old) : '0;
  assign w_ram_raddr = w_dump_go ? r_idx[AW-1:0] : r_s1_addr;

  assign busy        = (r_state == ST_CLEAR) || (r_state == ST_DUMP);
  assign m_data      = r_m_data;
  assign m_valid     = r_m_valid;
  assign m_last      = r_m_last;
  assign o_dbg_state = r_state;

  // Select the readout word: bins first, then the three counters
  always_comb begin
    w_word = r_total;
    if (r_idx < IDX_COINC)       w_word = w_ram_q;
    else if (r_idx == IDX_COINC) w_word = r_coinc;
    else if (r_idx == IDX_AUTO)  w_word = r_auto;
  end

  tdc_hist_ram #(.DW(CNT_W), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q)
  );

  // Two-flop synchroniser plus a delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= data_arrived;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Bin RMW pipeline: stage 1 reads the bin, stage 2 writes the increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_fwd_valid <= 1'b0;
      r_s1_addr   <= '0;
      r_s2_addr   <= '0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_s1_valid  <= w_accept && (w_kind == EV_CROSS);
      r_s1_addr   <= w_bin_addr;
      r_s2_valid  <= r_s1_valid;
      r_s2_addr   <= r_s1_addr;
      r_fwd_valid <= r_s2_valid;
      r_fwd_addr  <= r_s2_addr;
      r_fwd_data  <= w_ram_wdata;
    end
  end

  // Saturating event counters, zeroed while CLEAR sweeps the RAM
  always_ff @(posedge clk) begin
    if (rst || w_clr_we) begin
      r_coinc <= '0;
      r_auto  <= '0;
      r_total <= '0;
    end else if (w_accept) begin
      r_total <= sat_inc(r_total);
      if (w_kind == EV_COINC)     r_coinc <= sat_inc(r_coinc);
      else if (w_kind == EV_AUTO) r_auto  <= sat_inc(r_auto);
    end
  end

  // Control FSM, clear address sweep and readout stream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_clr_addr <= '0;
      r_idx      <= '0;
      r_rd_pend  <= 1'b0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACQ: begin
          if (clear_req) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
          end else if (dump_req) begin
            r_state   <= ST_DUMP;
            r_idx     <= '0;
            r_rd_pend <= 1'b0;
          end else if (r_state == ST_IDLE) begin
            if (acq_en) r_state <= ST_ACQ;
          end else if (!acq_en && !w_pipe_busy) begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (w_clr_we) begin
            r_clr_addr <= r_clr_addr + AW'(1);
            if (r_clr_addr == TOP_ADDR) r_state <= ST_IDLE;
          end
        end
        ST_DUMP: begin
          if (w_dump_go) begin
            if (r_rd_pend) begin
              r_m_data  <= w_word;
              r_m_valid <= 1'b1;
              r_m_last  <= (r_idx == IDX_LAST);
              r_rd_pend <= 1'b0;
            end else if (r_m_valid) begin
              if (m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
                if (r_m_last) r_state <= ST_IDLE;
                else          r_idx   <= r_idx + IW'(1);
              end
            end else begin
              r_rd_pend <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tdc_hist_reader.md
TDC_HIST_READER -- requirements
Module: tdc_hist_reader

Interface
REQ-001 Parameters: CNT_W, default 16, width of each histogram bin and counter; NBINS, default 128, number of histogram bins indexed by the TDC interval.
REQ-002 clk  input  1  system clock, 500 MHz, same clock domain as the TDC.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 START_signal  input  2  TDC start-channel code {pulse1,pulse2}.
REQ-005 END_signal  input  2  TDC end-channel code {pulse1,pulse2}.
REQ-006 INTERVAL  input  7  TDC interval, in 2 ns ticks.
REQ-007 data_arrived  input  1  TDC event strobe, asynchronous to clk, held at least 2 clk cycles.
REQ-008 acq_en  input  1  level signal; 1 = accumulate events.
REQ-009 clear_req  input  1  single-cycle pulse; zero all bins and counters.
REQ-010 dump_req  input  1  single-cycle pulse; stream out the histogram.
REQ-011 busy  output  1  high in CLEAR and DUMP states.
REQ-012 m_data  output  CNT_W  readout word.
REQ-013 m_valid  output  1  readout word is valid.
REQ-014 m_ready  input  1  downstream accepts the word.
REQ-015 m_last  output  1  marks the final word of a dump.

Function
REQ-016 data_arrived shall pass through a 2-flop synchronizer and a rising-edge detector; the detected edge is the event, and it occurs 3 clk cycles after data_arrived rises.
REQ-017 START_signal, END_signal and INTERVAL shall be registered on the event cycle, while the strobe is still high.
REQ-018 Event classification:
  - START=00, END=11 -> zero-delay coincidence; coinc_cnt++.
  - START=10 with END=01, or START=01 with END=10 -> cross event; bin[INTERVAL]++.
  - Any other code -> auto event; auto_cnt++.
REQ-019 Every event with acq_en=1 shall increment total_cnt; events with acq_en=0 or in a non-ACQ state shall be dropped without side effects.
REQ-020 All counters shall saturate at 2^CNT_W-1 and shall never wrap.
REQ-021 Bins shall be held in a single-port-per-side RAM (NBINS x CNT_W) with a 2-stage read-modify-write pipeline; a back-to-back event to the same bin shall forward the in-flight value so that no increment is lost.
REQ-022 States:
  - IDLE: acq_en=1 -> ACQ; clear_req -> CLEAR; dump_req -> DUMP.
  - ACQ: accumulate; acq_en=0 -> IDLE after the pipeline drains; clear_req -> CLEAR; dump_req -> DUMP.
REQ-023 CLEAR shall write zero to address 0..NBINS-1, one address per cycle, and zero all counters, then return to IDLE; it takes NBINS cycles.
REQ-024 DUMP shall emit NBINS+3 words in this order: bin[0..NBINS-1], coinc_cnt, auto_cnt, total_cnt; m_last is asserted on total_cnt; the state then returns to IDLE.
REQ-025 Handshake: a word transfers on m_valid & m_ready; m_data and m_valid shall stay stable while m_ready=0; m_valid shall not depend combinationally on m_ready.
REQ-026 clear_req and dump_req arriving while busy=1 shall be ignored.
REQ-027 If clear_req and dump_req are asserted in the same cycle, clear_req wins.
REQ-028 The pending RMW pipeline shall complete before CLEAR or DUMP starts its first address.
REQ-029 Events are not accumulated during DUMP; dumping does not modify any contents.

Reset
REQ-030 On rst=1: state=IDLE, busy=0, m_valid=0, m_last=0, m_data=0, all counters and synchronizer flops zero, RMW pipeline flushed.
REQ-031 Histogram RAM contents are undefined after reset; a CLEAR is required before use.
REQ-032 rst asserted mid-DUMP or mid-CLEAR shall abort the operation within the same cycle.

Structure
REQ-033 A shared package shall hold CNT_W, NBINS, the state enum, and the channel code constants (CODE_COINC_START=00, CODE_COINC_END=11, CODE_P1=10, CODE_P2=01).
REQ-034 Exactly one sub-module shall be used: tdc_hist_ram, a simple dual-port synchronous RAM with 1-cycle read latency.

Verification
REQ-035 CLEAR, then ACQ, then one event with START=10, END=01, INTERVAL=5 -> DUMP gives bin[5]=1, all other bins 0, coinc=0, auto=0, total=1, m_last on word 130.
REQ-036 Two events with START=00, END=11 plus one event with START=10, END=10 -> coinc_cnt=2, auto_cnt=1, total_cnt=3, all bins 0.
REQ-037 Cross events to INTERVAL=7 spaced at the minimum legal spacing (4 clk), 10 events -> bin[7]=10 (tests forwarding).
REQ-038 Bin preloaded to 0xFFFE, then 3 cross events to that bin -> bin reads 0xFFFF.
REQ-039 DUMP with m_ready toggled randomly at 50% -> all 131 words are received in order, m_data is stable while stalled, and exactly one m_last occurs.
REQ-040 rst asserted at DUMP word 40 -> next cycle m_valid=0 and state=IDLE; a following CLEAR and DUMP returns all zeros.
